delay_line_array: RTL and testbench

Parametrised multi-channel synchronous delay line: each of CHANNELS lanes delays a WIDTH-bit input by a per-lane programmable number of clock cycles (1..DEPTH). It is the configurable successor to the single fixed delay-line design. It sits directly behind the top-level pin wrapper, with lane inputs and outputs mapped onto dedicated pins. Delay reprogramming uses a valid/ready handshake, with deterministic output blanking while a lane settles.

---
 rtl/delay_line_array_if.sv | 31 +++
 rtl/delay_line_array.sv | 105 ++++++++++
 tb/tb_delay_line_array.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/delay_line_array_if.sv
// Bus bundle for delay_line_array: lane data, delay-config handshake and edge-counter readout.
interface delay_line_array_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 16
);
    localparam int DW = $clog2(DEPTH);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      ena;
    logic [CHANNELS*WIDTH-1:0] din;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [CW-1:0]             cfg_chan;
    logic [DW-1:0]             cfg_delay;
    logic [CHANNELS-1:0]       busy;
    logic [CW-1:0]             cnt_sel;
    logic                      cnt_clr;
    logic [7:0]                cnt_out;

    modport master (
        output ena, din, cfg_valid, cfg_chan, cfg_delay, cnt_sel, cnt_clr,
        input  dout, cfg_ready, busy, cnt_out
    );

    modport slave (
        input  ena, din, cfg_valid, cfg_chan, cfg_delay, cnt_sel, cnt_clr,
        output dout, cfg_ready, busy, cnt_out
    );
endinterface

// File: rtl/delay_line_array.sv
// Multi-lane programmable delay line with per-lane flush on reconfiguration.
// Optional per-lane rising-edge counters are built when DLY_EDGE_CNT_EN is defined.
module delay_line_array #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 16
) (
    input logic               clk,
    input logic               rst_n,
    delay_line_array_if.slave bus
);
    localparam int DW = $clog2(DEPTH);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DW:0] FC_ONE = 1;

    typedef enum logic {RUN, FLUSH} lane_state_t;

    logic [WIDTH-1:0]          r_sr    [CHANNELS][DEPTH];
    logic [DW-1:0]             r_delay [CHANNELS];
    logic [DW:0]               r_fc    [CHANNELS];
    lane_state_t               r_state [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] r_dout;
    logic [CHANNELS*WIDTH-1:0] w_doutNext;
    logic [CHANNELS-1:0]       w_busy;
    logic                      w_cfgReady;
    logic                      w_accept;
    logic [7:0]                w_cntOut;

    // Output tap reads the pre-shift history at the lane's delay; flushing lanes are blanked.
    always_comb begin
        w_busy     = '0;
        w_doutNext = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_busy[c] = (r_state[c] == FLUSH);
            w_doutNext[c*WIDTH +: WIDTH] = (r_state[c] == FLUSH) ? '0 : r_sr[c][r_delay[c]];
        end
    end

    assign w_cfgReady = bus.ena & ~|w_busy;
    assign w_accept   = bus.cfg_valid & w_cfgReady;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_delay[c] <= '0;
                r_fc[c]    <= '0;
                r_state[c] <= RUN;
                for (int i = 0; i < DEPTH; i++) begin
                    r_sr[c][i] <= '0;
                end
            end
        end else if (bus.ena) begin
            r_dout <= w_doutNext;
            for (int c = 0; c < CHANNELS; c++) begin
                r_sr[c][0] <= bus.din[c*WIDTH +: WIDTH];
                for (int i = 1; i < DEPTH; i++) begin
                    r_sr[c][i] <= r_sr[c][i-1];
                end
                // Out-of-range channel codes never match a lane, so they complete as no-ops.
                if (w_accept && (bus.cfg_chan == CW'(c))) begin
                    r_delay[c] <= bus.cfg_delay;
                    r_fc[c]    <= {1'b0, bus.cfg_delay} + FC_ONE;
                    r_state[c] <= FLUSH;
                end else if (r_state[c] == FLUSH) begin
                    r_fc[c] <= r_fc[c] - FC_ONE;
                    if (r_fc[c] == FC_ONE) begin
                        r_state[c] <= RUN;
                    end
                end
            end
        end
    end

`ifdef DLY_EDGE_CNT_EN
    logic [7:0] r_cnt [CHANNELS];

    // Clear takes priority over a coincident rising edge; counts saturate at 255.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (!rst_n || bus.cnt_clr) begin
                r_cnt[c] <= '0;
            end else if (bus.ena && !r_dout[c*WIDTH] && w_doutNext[c*WIDTH] && (r_cnt[c] != 8'hFF)) begin
                r_cnt[c] <= r_cnt[c] + 8'd1;
            end
        end
    end

    always_comb begin
        w_cntOut = '0;
        if (int'(bus.cnt_sel) < CHANNELS) begin
            w_cntOut = r_cnt[bus.cnt_sel];
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{bus.cnt_sel, bus.cnt_clr};
    assign w_cntOut = '0;
`endif

    assign bus.dout      = r_dout;
    assign bus.busy      = w_busy;
    assign bus.cfg_ready = w_cfgReady;
    assign bus.cnt_out   = w_cntOut;
endmodule

// File: tb/tb_delay_line_array.sv
// Directed self-checking bench for delay_line_array (4 lanes, 1 bit, depth 16).
module tb_delay_line_array;
    localparam int CHANNELS = 4;
    localparam int WIDTH    = 1;
    localparam int DEPTH    = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    delay_line_array_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    delay_line_array #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.ena       = 1'b1;
        bus.din       = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_chan  = '0;
        bus.cfg_delay = '0;
        bus.cnt_sel   = '0;
        bus.cnt_clr   = 1'b0;
        applyStimulus(2);
        checkOutput("rst_dout", 32'(bus.dout), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_ready", 32'(bus.cfg_ready), 32'h1);
        checkOutput("rst_cnt", 32'(bus.cnt_out), 32'h0);
        rst_n = 1'b1;

        // Default delay code 0: single pulse emerges one edge after it is sampled.
        bus.din = 4'b0001;
        applyStimulus(1);
        checkOutput("d0_not_yet", 32'(bus.dout), 32'h0);
        bus.din = 4'b0000;
        applyStimulus(1);
        checkOutput("d0_pulse", 32'(bus.dout), 32'h1);
        applyStimulus(1);
        checkOutput("d0_after", 32'(bus.dout), 32'h0);

        // Lane2 reprogrammed to D=9 while its input toggles every cycle.
        bus.din = 4'b0001;
        applyStimulus(2);
        bus.cfg_valid = 1'b1;
        bus.cfg_chan  = 2'd2;
        bus.cfg_delay = 4'd9;
        applyStimulus(1);
        bus.cfg_valid = 1'b0;
        checkOutput("l2_busy_start", 32'(bus.busy), 32'h4);
        checkOutput("l2_ready_low", 32'(bus.cfg_ready), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            bus.din[2] = k[0];
            applyStimulus(1);
            checkOutput("l2_blank", 32'(bus.dout[2]), 32'h0);
            checkOutput("l2_busy", 32'(bus.busy), (k < 10) ? 32'h4 : 32'h0);
            checkOutput("l2_lane0", 32'(bus.dout[0]), 32'h1);
        end
        checkOutput("l2_ready_back", 32'(bus.cfg_ready), 32'h1);
        for (int k = 11; k <= 13; k++) begin
            bus.din[2] = k[0];
            applyStimulus(1);
            checkOutput("l2_data", 32'(bus.dout[2]), 32'((k - 10) & 1));
        end

        // Request held for lane1 while lane0 flushes with D=15.
        bus.din       = 4'b0001;
        bus.cfg_valid = 1'b1;
        bus.cfg_chan  = 2'd0;
        bus.cfg_delay = 4'd15;
        applyStimulus(1);
        bus.cfg_chan  = 2'd1;
        bus.cfg_delay = 4'd3;
        for (int n = 1; n <= 16; n++) begin
            applyStimulus(1);
            checkOutput("hold_busy", 32'(bus.busy), (n < 16) ? 32'h1 : 32'h0);
        end
        checkOutput("hold_ready", 32'(bus.cfg_ready), 32'h1);
        applyStimulus(1);
        bus.cfg_valid = 1'b0;
        checkOutput("hold_accept", 32'(bus.busy), 32'h2);
        applyStimulus(4);
        checkOutput("hold_done", 32'(bus.busy), 32'h0);

        // Lane3 D=5 flush with enable dropped for four cycles.
        bus.din       = 4'b1001;
        bus.cfg_valid = 1'b1;
        bus.cfg_chan  = 2'd3;
        bus.cfg_delay = 4'd5;
        applyStimulus(1);
        bus.cfg_valid = 1'b0;
        checkOutput("ena_busy0", 32'(bus.busy), 32'h8);
        applyStimulus(2);
        checkOutput("ena_busy2", 32'(bus.busy), 32'h8);
        bus.ena = 1'b0;
        checkOutput("ena_ready_low", 32'(bus.cfg_ready), 32'h0);
        applyStimulus(4);
        checkOutput("ena_frz_busy", 32'(bus.busy), 32'h8);
        checkOutput("ena_frz_dout", 32'(bus.dout[3]), 32'h0);
        checkOutput("ena_frz_ready", 32'(bus.cfg_ready), 32'h0);
        bus.ena = 1'b1;
        applyStimulus(3);
        checkOutput("ena_busy5", 32'(bus.busy), 32'h8);
        applyStimulus(1);
        checkOutput("ena_busy6", 32'(bus.busy), 32'h0);
        checkOutput("ena_blank6", 32'(bus.dout[3]), 32'h0);
        applyStimulus(1);
        checkOutput("ena_data", 32'(bus.dout[3]), 32'h1);

        // Reset in the middle of a lane3 D=15 flush.
        bus.cfg_valid = 1'b1;
        bus.cfg_chan  = 2'd3;
        bus.cfg_delay = 4'd15;
        applyStimulus(1);
        bus.cfg_valid = 1'b0;
        applyStimulus(3);
        checkOutput("mid_busy", 32'(bus.busy), 32'h8);
        bus.din = 4'b0000;
        rst_n   = 1'b0;
        applyStimulus(1);
        rst_n = 1'b1;
        checkOutput("mrst_busy", 32'(bus.busy), 32'h0);
        checkOutput("mrst_dout", 32'(bus.dout), 32'h0);
        checkOutput("mrst_ready", 32'(bus.cfg_ready), 32'h1);
        bus.din = 4'b1000;
        applyStimulus(1);
        checkOutput("mrst_pre", 32'(bus.dout), 32'h0);
        bus.din = 4'b0000;
        applyStimulus(1);
        checkOutput("mrst_pulse", 32'(bus.dout), 32'h8);
        applyStimulus(1);
        checkOutput("mrst_post", 32'(bus.dout), 32'h0);

        // Lane1 rising-edge counter.
        bus.cnt_sel = 2'd1;
`ifdef DLY_EDGE_CNT_EN
        repeat (10) begin
            bus.din = 4'b0010;
            applyStimulus(1);
            bus.din = 4'b0000;
            applyStimulus(1);
        end
        checkOutput("cnt_10", 32'(bus.cnt_out), 32'd10);
        repeat (290) begin
            bus.din = 4'b0010;
            applyStimulus(1);
            bus.din = 4'b0000;
            applyStimulus(1);
        end
        checkOutput("cnt_sat", 32'(bus.cnt_out), 32'd255);
        bus.din = 4'b0010;
        applyStimulus(1);
        bus.din     = 4'b0000;
        bus.cnt_clr = 1'b1;
        applyStimulus(1);
        bus.cnt_clr = 1'b0;
        checkOutput("cnt_clr_wins", 32'(bus.cnt_out), 32'd0);
        checkOutput("cnt_clr_dout", 32'(bus.dout[1]), 32'h1);
        applyStimulus(1);
        bus.din = 4'b0010;
        applyStimulus(1);
        bus.din = 4'b0000;
        applyStimulus(1);
        checkOutput("cnt_one", 32'(bus.cnt_out), 32'd1);
`else
        repeat (10) begin
            bus.din = 4'b0010;
            applyStimulus(1);
            bus.din = 4'b0000;
            applyStimulus(1);
        end
        checkOutput("cnt_off", 32'(bus.cnt_out), 32'd0);
        bus.cnt_clr = 1'b1;
        applyStimulus(1);
        bus.cnt_clr = 1'b0;
        checkOutput("cnt_off_clr", 32'(bus.cnt_out), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
